// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch-side push, decode-side show-ahead and flush/stall signals of the fetch queue.
// master drives fetch/decode control, slave is the queue itself.
interface inst_fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             in_adel;
  logic             in_ready;
  logic             stallD;
  logic             validD;
  logic [31:0]      instrD;
  logic [31:0]      pcD;
  logic             adelD;
  logic [PTR_W:0]   count;
  modport master (
    output flush, in_valid, in_pc, in_instr, in_adel, stallD,
    input  in_ready, validD, instrD, pcD, adelD, count
  );
  modport slave (
    input  flush, in_valid, in_pc, in_instr, in_adel, stallD,
    output in_ready, validD, instrD, pcD, adelD, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: show-ahead circular instruction queue between fetch and decode.
// Define IFQ_BYPASS_EN to let an incoming word reach decode in the same cycle when the queue is empty.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_queue_if.slave ifq
);
  logic [64:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty, full, byp, push, pop;
  logic [64:0]      head;
  assign empty = count_q == '0;
  assign full  = count_q == (PTR_W+1)'(DEPTH);
`ifdef IFQ_BYPASS_EN
  assign byp = empty & ifq.in_valid;
`else
  assign byp = 1'b0;
`endif
  // a bypassed word consumed this cycle never enters storage
  assign pop  = ~empty & ~ifq.stallD & ~ifq.flush & ~rst;
  assign push = ifq.in_valid & ~full & ~ifq.flush & ~rst & ~(byp & ~ifq.stallD);
  assign head = empty ? (byp ? {ifq.in_pc, ifq.in_instr, ifq.in_adel} : '0) : mem_q[rd_ptr_q];
  always_comb begin
    rd_ptr_d = ifq.flush ? '0 : rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = ifq.flush ? '0 : wr_ptr_q + PTR_W'(push);
    count_d  = ifq.flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ifq.in_pc, ifq.in_instr, ifq.in_adel};
  end
  assign ifq.in_ready = ~full;
  assign ifq.validD   = ~empty | byp;
  assign {ifq.pcD, ifq.instrD, ifq.adelD} = head;
  assign ifq.count    = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed and random scenarios checked against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [64:0] mdl[$];
  inst_fetch_queue_if #(.PTR_W(2)) bus();
  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (.clk(clk), .rst(rst), .ifq(bus));
  always #5 clk = ~clk;

  function automatic logic byp_now();
    return BYP && mdl.size() == 0 && bus.in_valid;
  endfunction

  function automatic logic [69:0] exp_vec();
    logic        v = (mdl.size() != 0) || byp_now();
    logic [64:0] w = (mdl.size() != 0) ? mdl[0] : (byp_now() ? {bus.in_pc, bus.in_instr, bus.in_adel} : 65'h0);
    logic [2:0]  c = 3'(mdl.size());
    logic        r = mdl.size() != DEPTH;
    return {v, w, c, r};
  endfunction

  function automatic logic [69:0] obs_vec();
    return {bus.validD, bus.pcD, bus.instrD, bus.adelD, bus.count, bus.in_ready};
  endfunction

  task automatic drive(logic v, logic [31:0] pc, logic [31:0] ins, logic a, logic st, logic fl);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = ins;
    bus.in_adel  = a;
    bus.stallD   = st;
    bus.flush    = fl;
    #1;
  endtask

  // advance one clock and apply the queue rules to the model
  task automatic tick();
    logic pop, full, bypassed;
    @(posedge clk);
    pop      = ((mdl.size() != 0) || byp_now()) && !bus.stallD;
    full     = mdl.size() == DEPTH;
    bypassed = byp_now() && pop;
    if (rst || bus.flush) mdl.delete();
    else if (!bypassed) begin
      if (pop) void'(mdl.pop_front());
      if (bus.in_valid && !full) mdl.push_back({bus.in_pc, bus.in_instr, bus.in_adel});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, $urandom, $urandom, 1, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_vec() !== {1'b0, 65'h0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs_vec(), {1'b0, 65'h0, 3'd0, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 4 * i, $urandom, 0, 1, 0);
      tick();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_vec() !== {1'b0, 65'h0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset got %h exp %h", obs_vec(), {1'b0, 65'h0, 3'd0, 1'b1});
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 32'hBFC00000, 32'h24020001, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single c%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h00400000 + 4 * i, $urandom, 0, 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill c%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if ({bus.count, bus.in_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full got count %0d ready %0b exp count 4 ready 0", bus.count, bus.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drain c%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'h00800000 + 4 * i, $urandom, 0, i < 2, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stream c%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 1, 2: drive(1, 32'h00C00000 + 4 * i, $urandom, 0, 1, 0);
        3:       drive(1, 32'hDEAD0000, 32'hDEADBEEF, 0, 0, 1);
        4:       drive(1, 32'h80000180, 32'h3C1A8000, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0);
      endcase
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL flush c%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_adel();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 32'h00000003, $urandom, 1, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL adel c%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 59) == 0;
      drive($urandom_range(0, 2) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_adel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch queue feeding the decode stage.
- Buffers instruction words returned by the instruction cache/memory interface together with their PC and fetch-exception tag. It presents them in order to the main decoder, which consumes one word per cycle whenever stallD is low.
- Sits between the fetch stage and the decode-stage control decoder.
- Flush support covers branch redirects and exceptions/ERET.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all queued entries (branch redirect, exception, ERET).
- in_valid  input  1  fetch side offers a word this cycle.
- in_pc  input  32  PC of the offered word.
- in_instr  input  32  offered instruction word.
- in_adel  input  1  fetch address-error tag for the offered word.
- in_ready  output  1  queue can accept a word this cycle.
- stallD  input  1  decode stage stalled; no word is consumed.
- validD  output  1  instrD/pcD/adelD hold a real queued word.
- instrD  output  32  instruction word presented to decode.
- pcD  output  32  PC of the presented word.
- adelD  output  1  fetch-exception tag of the presented word.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset: clk rising edge with rst=1 → rd_ptr=0, wr_ptr=0, count=0. Outputs then read in_ready=1, validD=0, instrD=32'h0, pcD=32'h0, adelD=0. Entry storage is not cleared.
- Storage: DEPTH entries of {pc[31:0], instr[31:0], adel}, circular. Pointers wrap from DEPTH-1 to 0 by natural PTR_W-bit overflow.
- Full/empty: full = (count==DEPTH), empty = (count==0). in_ready = ~full and does not depend on the same-cycle pop; a full queue never accepts, even when popping.
- Push: in_valid & in_ready & ~flush & ~rst. Writes the entry at wr_ptr, then wr_ptr+1.
- Pop: validD & ~stallD & ~flush & ~rst. Then rd_ptr+1.
- count update: push & pop → unchanged; push only → +1; pop only → -1.
- Show-ahead output:
  - Not empty: validD=1 and instrD/pcD/adelD = entry[rd_ptr].
  - Empty: validD=0 and instrD=32'h0 (decodes as SLL $0, a harmless NOP), pcD=32'h0, adelD=0.
- Latency: a word pushed in cycle N is visible at the decode outputs in cycle N+1 (without the optional feature).
- Ordering: strict FIFO; no word is duplicated or dropped except by flush/rst.
- Flush: takes effect at the clock edge.
  - Next cycle: pointers=0, count=0, validD=0.
  - Any push or pop in the flush cycle is ignored.
  - flush has priority over push/pop; rst has priority over flush.
- stallD high with the queue empty has no effect.
- stallD held high while full: contents frozen, in_ready=0, outputs stable.
- Reset mid-operation: same as power-on reset; all queued words are lost.
- No combinational path from stallD to in_ready.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when the queue is empty and in_valid=1, the incoming word drives validD/instrD/pcD/adelD combinationally in the same cycle.
  - If consumed that cycle (~stallD & ~flush), it is not written and count stays 0.
  - If stallD=1, it is pushed normally.
  - Zero-cycle latency on an empty queue.
- Undefined: no in→out combinational path; minimum latency is 1 cycle.

Test Plan:
- Reset → after one edge with rst=1: count=0, validD=0, instrD=32'h0, in_ready=1.
- Push 0x24020001 (pc 0xBFC00000), stallD=0 → next cycle validD=1, instrD=0x24020001, pcD=0xBFC00000; one cycle later count=0, validD=0.
- stallD=1, push 4 words (pcs 0x...00,04,08,0C) → count=4, in_ready=0. A 5th in_valid is not accepted.
  - Then stallD=0 → instrD sequence in order over 4 cycles, count 4,3,2,1,0; read-pointer wrap is exercised.
- Queue count=2 with in_valid=1, stallD=0 every cycle → count stays 2 and output order matches input order across ≥8 words; pointer wrap is exercised.
- Queue count=3, assert flush with in_valid=1 and stallD=0 → next cycle count=0, validD=0; the flush-cycle word is absent. The first post-flush push appears at the output next cycle.
- Push with in_adel=1, pc 0x00000003 → adelD=1, pcD=0x00000003 when that entry is presented. With IFQ_BYPASS_EN, an empty queue shows it in the same cycle and count stays 0.
